// File: rtl/exe_arb_w15_if.sv
// exe_arb_w15_if: requester, ALU drive/return and response signals of the ALU arbiter.
interface exe_arb_w15_if #(parameter int ARG_BITS = 4);
    logic                i_req0, i_req1;
    logic [1:0]          i_oper0, i_oper1;
    logic [ARG_BITS-1:0] i_argA0, i_argA1, i_argB0, i_argB1;
    logic                o_gnt0, o_gnt1;
    logic [1:0]          o_alu_oper;
    logic [ARG_BITS-1:0] o_alu_argA, o_alu_argB;
    logic [ARG_BITS-1:0] i_alu_result;
    logic [3:0]          i_alu_status;
    logic                o_rsp_valid, i_rsp_ready, o_rsp_id;
    logic [ARG_BITS-1:0] o_rsp_result;
    logic [3:0]          o_rsp_status;
    logic                o_busy;
    modport slave (
        input  i_req0, i_req1, i_oper0, i_oper1, i_argA0, i_argA1, i_argB0, i_argB1,
               i_alu_result, i_alu_status, i_rsp_ready,
        output o_gnt0, o_gnt1, o_alu_oper, o_alu_argA, o_alu_argB,
               o_rsp_valid, o_rsp_id, o_rsp_result, o_rsp_status, o_busy
    );
    modport master (
        output i_req0, i_req1, i_oper0, i_oper1, i_argA0, i_argA1, i_argB0, i_argB1,
               i_alu_result, i_alu_status, i_rsp_ready,
        input  o_gnt0, o_gnt1, o_alu_oper, o_alu_argA, o_alu_argB,
               o_rsp_valid, o_rsp_id, o_rsp_result, o_rsp_status, o_busy
    );
endinterface

// File: rtl/exe_arb_w15.sv
// exe_arb_w15: two-requester round-robin sequencer for one shared pipelined ALU.
module exe_arb_w15 #(
    parameter int ARG_BITS = 4,
    parameter int ALU_LAT  = 1
) (
    input logic         i_clk,
    input logic         i_rsn,
    exe_arb_w15_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t              state, next;
    logic                rr_ptr, id, valid, gnt0, gnt1;
    logic [2:0]          cnt;
    logic [1:0]          oper;
    logic [ARG_BITS-1:0] arg_a, arg_b, result;
    logic [3:0]          status;
    // grants are gated by reset so nothing is offered while held in reset
    always_comb begin
        next = state;
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state)
            IDLE: begin
                gnt0 = i_rsn & bus.i_req0 & (~bus.i_req1 | ~rr_ptr);
                gnt1 = i_rsn & bus.i_req1 & (~bus.i_req0 | rr_ptr);
                next = (gnt0 | gnt1) ? EXEC : IDLE;
            end
            EXEC:    next = (cnt == 3'd0) ? RESP : EXEC;
            RESP:    next = bus.i_rsp_ready ? IDLE : RESP;
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            state  <= IDLE;
            rr_ptr <= 1'b0;
            cnt    <= 3'd0;
            id     <= 1'b0;
            valid  <= 1'b0;
            oper   <= 2'd0;
            arg_a  <= '0;
            arg_b  <= '0;
            result <= '0;
            status <= 4'd0;
        end else begin
            state <= next;
            if (gnt0 | gnt1) begin
                oper  <= gnt1 ? bus.i_oper1 : bus.i_oper0;
                arg_a <= gnt1 ? bus.i_argA1 : bus.i_argA0;
                arg_b <= gnt1 ? bus.i_argB1 : bus.i_argB0;
                id    <= gnt1;
                cnt   <= 3'(ALU_LAT);
            end
            if (state == EXEC) begin
                if (cnt != 3'd0) cnt <= cnt - 3'd1;
                else begin
                    result <= bus.i_alu_result;
                    status <= bus.i_alu_status;
                    valid  <= 1'b1;
                end
            end
            if (state == RESP && bus.i_rsp_ready) begin
                valid  <= 1'b0;
                rr_ptr <= ~id;
            end
        end
    end
    assign bus.o_gnt0       = gnt0;
    assign bus.o_gnt1       = gnt1;
    assign bus.o_alu_oper   = oper;
    assign bus.o_alu_argA   = arg_a;
    assign bus.o_alu_argB   = arg_b;
    assign bus.o_rsp_valid  = valid;
    assign bus.o_rsp_id     = id;
    assign bus.o_rsp_result = result;
    assign bus.o_rsp_status = status;
    assign bus.o_busy       = (state != IDLE);
endmodule

// File: tb/tb_exe_arb_w15.sv
// tb_exe_arb_w15: directed checks of the ALU arbiter with 1- and 3-cycle ALU models.
module tb_exe_arb_w15;
    logic clk = 1'b0;
    logic rsn = 1'b0;
    int   tests = 0;
    int   fails = 0;
    always #5 clk = ~clk;

    exe_arb_w15_if #(.ARG_BITS(4)) ifa ();
    exe_arb_w15_if #(.ARG_BITS(4)) ifb ();
    exe_arb_w15 #(.ARG_BITS(4), .ALU_LAT(1)) dut_a (.i_clk(clk), .i_rsn(rsn), .bus(ifa));
    exe_arb_w15 #(.ARG_BITS(4), .ALU_LAT(3)) dut_b (.i_clk(clk), .i_rsn(rsn), .bus(ifb));

    // reference ALU: {status, result}, status = {carry, zero, neg, 0}
    function automatic logic [7:0] alu(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        s = (op == 2'd0) ? {1'b0, a} + {1'b0, b} :
            (op == 2'd1) ? {1'b0, a} - {1'b0, b} :
            (op == 2'd2) ? {1'b0, a & b} : {1'b0, a ^ b};
        return {s[4], s[3:0] == 4'd0, s[3], 1'b0, s[3:0]};
    endfunction

    logic [7:0] pa;
    logic [7:0] pb [3];
    always @(posedge clk) begin
        pa    <= alu(ifa.o_alu_oper, ifa.o_alu_argA, ifa.o_alu_argB);
        pb[0] <= alu(ifb.o_alu_oper, ifb.o_alu_argA, ifb.o_alu_argB);
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end
    assign ifa.i_alu_result = pa[3:0];
    assign ifa.i_alu_status = pa[7:4];
    assign ifb.i_alu_result = pb[2][3:0];
    assign ifb.i_alu_status = pb[2][7:4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [7:0] rsp_a();
        return {ifa.o_rsp_status, ifa.o_rsp_result};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        logic [7:0] held;
        {ifa.i_req0, ifa.i_req1, ifa.i_oper0, ifa.i_oper1} = '0;
        {ifa.i_argA0, ifa.i_argA1, ifa.i_argB0, ifa.i_argB1} = '0;
        ifa.i_rsp_ready = 1'b1;
        {ifb.i_req0, ifb.i_req1, ifb.i_oper0, ifb.i_oper1} = '0;
        {ifb.i_argA0, ifb.i_argA1, ifb.i_argB0, ifb.i_argB1} = '0;
        ifb.i_rsp_ready = 1'b1;

        // reset with toggling inputs
        for (int i = 0; i < 4; i++) begin
            cyc();
            {ifa.i_req0, ifa.i_req1, ifa.i_oper0, ifa.i_oper1} = 6'($urandom);
            {ifa.i_argA0, ifa.i_argA1, ifa.i_argB0, ifa.i_argB1} = 16'($urandom);
            #1;
            check("rst_gnt", {ifa.o_gnt0, ifa.o_gnt1}, 0);
        end
        check("rst_busy_valid", {ifa.o_busy, ifa.o_rsp_valid, ifa.o_rsp_id}, 0);
        check("rst_alu", {ifa.o_alu_oper, ifa.o_alu_argA, ifa.o_alu_argB}, 0);
        check("rst_rsp", rsp_a(), 0);
        check("rst_b", {ifb.o_busy, ifb.o_rsp_valid, ifb.o_gnt1}, 0);

        // release, both requesting: rr_ptr=0 picks requester 0, then alternate
        cyc();
        rsn = 1'b1;
        ifa.i_req0 = 1; ifa.i_oper0 = 2'd0; ifa.i_argA0 = 4'h1; ifa.i_argB0 = 4'h2;
        ifa.i_req1 = 1; ifa.i_oper1 = 2'd2; ifa.i_argA1 = 4'hC; ifa.i_argB1 = 4'hA;
        #1;
        check("rel_gnt", {ifa.o_gnt0, ifa.o_gnt1}, 2'b10);
        for (int n = 0; n < 4; n++) begin
            t = 0;
            while (!(ifa.o_gnt0 | ifa.o_gnt1) && t < 20) begin cyc(); t++; end
            check("fair_gnt_any", ifa.o_gnt0 | ifa.o_gnt1, 1);
            check("fair_gnt_id", ifa.o_gnt1, n % 2);
            t = 0;
            cyc();
            while (!ifa.o_rsp_valid && t < 20) begin cyc(); t++; end
            check("fair_rsp_id", ifa.o_rsp_id, n % 2);
            check("fair_rsp", rsp_a(), (n % 2) ? 8'h28 : 8'h03);
        end
        ifa.i_req0 = 0; ifa.i_req1 = 0;
        cyc();
        check("fair_idle", ifa.o_busy, 0);

        // single op, latency 1
        ifa.i_req0 = 1; ifa.i_oper0 = 2'b01; ifa.i_argA0 = 4'h3; ifa.i_argB0 = 4'h5;
        #1;
        check("one_gnt", {ifa.o_gnt0, ifa.o_gnt1}, 2'b10);
        cyc();
        check("one_gnt_drop", ifa.o_gnt0, 0);
        check("one_alu", {ifa.o_alu_oper, ifa.o_alu_argA, ifa.o_alu_argB}, 10'h135);
        check("one_busy", {ifa.o_busy, ifa.o_rsp_valid}, 2'b10);
        ifa.i_req0 = 0;
        cyc();
        check("one_k1", ifa.o_rsp_valid, 0);
        cyc();
        check("one_k2", {ifa.o_rsp_valid, ifa.o_rsp_id}, 2'b10);
        check("one_rsp", rsp_a(), 8'hAE);
        cyc();
        check("one_done", {ifa.o_rsp_valid, ifa.o_busy}, 0);

        // backpressure: req0 served, req1 waits behind a stalled response
        ifa.i_rsp_ready = 0;
        ifa.i_req0 = 1; ifa.i_oper0 = 2'd3; ifa.i_argA0 = 4'h6; ifa.i_argB0 = 4'h3;
        cyc();
        ifa.i_req0 = 0;
        ifa.i_req1 = 1; ifa.i_oper1 = 2'd0; ifa.i_argA1 = 4'h7; ifa.i_argB1 = 4'h7;
        cyc();
        cyc();
        check("bp_valid", ifa.o_rsp_valid, 1);
        held = rsp_a();
        check("bp_rsp", held, 8'h05);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("bp_hold", {ifa.o_rsp_valid, ifa.o_rsp_id, ifa.o_gnt1, rsp_a()}, {3'b100, 8'h05});
        end
        ifa.i_rsp_ready = 1;
        #1;
        check("bp_no_gnt", ifa.o_gnt1, 0);
        cyc();
        check("bp_after", {ifa.o_rsp_valid, ifa.o_gnt1}, 2'b01);
        cyc();
        ifa.i_req1 = 0;
        cyc();
        cyc();
        check("bp_r1", {ifa.o_rsp_valid, ifa.o_rsp_id, rsp_a()}, {2'b11, 8'h2E});
        cyc();

        // reset in the middle of EXEC
        ifa.i_req0 = 1; ifa.i_oper0 = 2'd1; ifa.i_argA0 = 4'h9; ifa.i_argB0 = 4'h2;
        cyc();
        ifa.i_req0 = 0;
        check("mid_busy", ifa.o_busy, 1);
        #2 rsn = 1'b0;
        #1;
        check("mid_rst", {ifa.o_busy, ifa.o_rsp_valid, ifa.o_alu_oper, ifa.o_alu_argA, ifa.o_alu_argB}, 0);
        cyc();
        rsn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("mid_no_rsp", {ifa.o_rsp_valid, ifa.o_busy}, 0);
        end
        ifa.i_req1 = 1; ifa.i_oper1 = 2'd2; ifa.i_argA1 = 4'hF; ifa.i_argB1 = 4'h3;
        #1;
        check("mid_gnt1", {ifa.o_gnt0, ifa.o_gnt1}, 2'b01);
        cyc();
        ifa.i_req1 = 0;
        cyc();
        cyc();
        check("mid_rsp", {ifa.o_rsp_valid, ifa.o_rsp_id, rsp_a()}, {2'b11, 8'h03});
        cyc();

        // latency 3
        ifb.i_req1 = 1; ifb.i_oper1 = 2'd0; ifb.i_argA1 = 4'hF; ifb.i_argB1 = 4'h1;
        #1;
        check("lat_gnt1", {ifb.o_gnt0, ifb.o_gnt1}, 2'b01);
        cyc();
        ifb.i_req1 = 0;
        for (int i = 1; i <= 3; i++) begin
            cyc();
            check("lat_wait", ifb.o_rsp_valid, 0);
        end
        cyc();
        check("lat_rsp", {ifb.o_rsp_valid, ifb.o_rsp_id, ifb.o_rsp_status, ifb.o_rsp_result}, {2'b11, 8'hC0});
        cyc();
        check("lat_done", {ifb.o_rsp_valid, ifb.o_busy}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
